// File: rtl/ex_mem_pipe_flags.sv
// EX/MEM pipeline register with optional signed saturation of ADD/SUB results and the N/Z/V flag register.
// Saturation is enabled by defining EXMEM_SAT_EN; otherwise results wrap. Latency 1 cycle; stall holds, flush bubbles.
module ex_mem_pipe_flags #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [3:0]        ex_opcode,
  input  logic [DATA_W-1:0] ex_sum,
  input  logic              ex_a_msb,
  input  logic              ex_b_msb,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_regwrite,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic [DATA_W-1:0] mem_store_data,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_v
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic              is_addsub;
  logic              is_zonly;
  logic              ovf;
  logic [DATA_W-1:0] res;

  always_comb begin
    is_addsub = (ex_opcode == OP_ADD) || (ex_opcode == OP_SUB);
    is_zonly  = (ex_opcode == OP_XOR) || (ex_opcode == OP_SLL) ||
                (ex_opcode == OP_SRA) || (ex_opcode == OP_ROR);
    // b_msb arrives already inverted for SUB, so one rule covers both ops
    ovf = is_addsub && (ex_a_msb == ex_b_msb) && (ex_sum[DATA_W-1] != ex_a_msb);
`ifdef EXMEM_SAT_EN
    res = ovf ? (ex_a_msb ? SAT_MIN : SAT_MAX) : ex_sum;
`else
    res = ex_sum;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_rd         <= '0;
      mem_regwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      mem_store_data <= '0;
      flag_n         <= 1'b0;
      flag_z         <= 1'b0;
      flag_v         <= 1'b0;
    end else if (flush) begin
      // data fields and flags deliberately hold through a bubble
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
    end else if (!stall) begin
      mem_valid      <= ex_valid;
      mem_result     <= res;
      mem_rd         <= ex_rd;
      mem_regwrite   <= ex_valid & ex_regwrite;
      mem_memread    <= ex_valid & ex_memread;
      mem_memwrite   <= ex_valid & ex_memwrite;
      mem_store_data <= ex_store_data;
      if (ex_valid) begin
        if (is_addsub) begin
          flag_n <= res[DATA_W-1];
          flag_z <= (res == '0);
          flag_v <= ovf;
        end else if (is_zonly) begin
          flag_z <= (res == '0);
        end
      end
    end
  end

endmodule
